// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a registered one-hot grant.
//
// A winner is picked from req by a rotating-priority search that starts at ptr.
// The grant is held until the owner raises done or drops its request. On
// release, priority rotates so that the previous winner becomes the lowest
// priority. There is always at least one idle cycle between two grants.
//
// Optional feature, enabled by defining the macro ARB_TIMEOUT_EN:
//   a hold counter forces a release after HOLD_MAX cycles in GRANT and
//   pulses timeout for one cycle. Without the macro, timeout is tied to 0.
//
// Parameters:
//   HOLD_MAX  max cycles a grant may be held (ARB_TIMEOUT_EN only), 1..2**CNT_W-1
//   CNT_W     hold counter width, 2**CNT_W > HOLD_MAX
//
// Ports:
//   clk        in   single clock, posedge
//   rst        in   synchronous reset, active-high
//   req[7:0]   in   request vector, bit i = requester i
//   done       in   owner releases the resource (only looked at in GRANT)
//   gnt[7:0]   out  registered one-hot grant, zero when idle
//   gnt_id     out  binary index of the owner, valid when gnt_valid=1
//   gnt_valid  out  high while a grant is held
//   timeout    out  one-cycle pulse on a forced release

module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q;
    logic [2:0] ptr_q;
    logic [2:0] win;
    logic       win_found;
    logic [2:0] idx;
    logic       rel;

    // Reject configurations where the counter cannot reach HOLD_MAX-1.
    if (HOLD_MAX < 1 || HOLD_MAX >= (1 << CNT_W)) begin : g_bad_cfg
        $error("rr_arbiter8: HOLD_MAX must be in 1..2**CNT_W-1");
    end

    // Rotating search: first set request at ptr, ptr+1, ... (mod 8).
    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        idx       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    // Owner lets go, either explicitly or by dropping its own request.
    assign rel = done || !req[gnt_id];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q;
    logic             timeout_q;
    logic             limit;

    assign limit   = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt        <= 8'h00;
            gnt_id     <= 3'd0;
            gnt_valid  <= 1'b0;
            ptr_q      <= 3'd0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timeout_q <= 1'b0;
                    if (win_found) begin
                        gnt_id     <= win;
                        gnt        <= 8'b1 << win;
                        gnt_valid  <= 1'b1;
                        hold_cnt_q <= '0;
                        state_q    <= StGrant;
                    end
                end
                StGrant: begin
                    // A normal release in the limit cycle wins over the timeout.
                    if (rel || limit) begin
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        ptr_q     <= gnt_id + 3'd1;
                        timeout_q <= !rel;
                        state_q   <= StIdle;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
`else
    assign timeout = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            ptr_q     <= 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        gnt_id    <= win;
                        gnt       <= 8'b1 << win;
                        gnt_valid <= 1'b1;
                        state_q   <= StGrant;
                    end
                end
                StGrant: begin
                    if (rel) begin
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        ptr_q     <= gnt_id + 3'd1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8. Built with HOLD_MAX=4 so the
// ARB_TIMEOUT_EN variant exercises a short forced release.

module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(
        .HOLD_MAX (4),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " gnt"}, 32'(gnt), 32'h00);
        check_eq({tag, " valid"}, 32'(gnt_valid), 32'd0);
    endtask

    task automatic check_grant(input string tag, input int id);
        check_eq({tag, " gnt"}, 32'(gnt), 32'(8'(1) << id));
        check_eq({tag, " id"}, 32'(gnt_id), 32'(id));
        check_eq({tag, " valid"}, 32'(gnt_valid), 32'd1);
    endtask

    initial begin
        // 1. Reset with all requests high.
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        tick();
        tick();
        check_eq("rst gnt", 32'(gnt), 32'h00);
        check_eq("rst valid", 32'(gnt_valid), 32'd0);
        check_eq("rst id", 32'(gnt_id), 32'd0);
        check_eq("rst timeout", 32'(timeout), 32'd0);

        // 3. Rotation from ptr=0: 0..7 then 0, with a bubble after each release.
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_grant($sformatf("rot%0d", k), k % 8);
            done = 1'b1;
            tick();
            check_idle($sformatf("rot%0d bubble", k));
            done = 1'b0;
        end
        req = 8'h00;
        tick();
        check_idle("idle no req");
        // ptr is now 1.

        // 2. Single request on bit 5; ptr becomes 6.
        req = 8'h20;
        tick();
        check_grant("single", 5);
        // Changing other requests mid-grant has no effect.
        req = 8'h3F;
        tick();
        check_grant("single hold", 5);
        req  = 8'h20;
        done = 1'b1;
        tick();
        check_idle("single rel");
        done = 1'b0;
        req  = 8'h00;
        tick();

        // 4. ptr=6 with req 0x41: 6 wins, then 0 (not 6 again).
        req = 8'h41;
        tick();
        check_grant("wrap first", 6);
        done = 1'b1;
        tick();
        check_idle("wrap rel");
        done = 1'b0;
        tick();
        check_grant("wrap second", 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();
        // ptr is now 1.

        // 5a. Owner drops its request while another is pending.
        req = 8'h06;
        tick();
        check_grant("drop first", 1);
        req = 8'h04;
        tick();
        check_idle("drop rel");
        tick();
        check_grant("drop next", 2);

        // done and req drop together: a single release, then idle.
        done = 1'b1;
        req  = 8'h00;
        tick();
        check_idle("both rel");
        done = 1'b0;
        tick();
        check_idle("both after");

        // 5b. Reset in the middle of a grant.
        req = 8'h80;
        tick();
        check_grant("pre rst", 7);
        rst = 1'b1;
        tick();
        check_idle("mid rst");
        check_eq("mid rst id", 32'(gnt_id), 32'd0);
        rst = 1'b0;
        req = 8'h00;
        tick();
        // ptr is back to 0.

        // 6. Requester 0 holds without done.
        req = 8'h01;
        tick();
        check_grant("hold c1", 0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 4; c++) begin
            tick();
            check_grant($sformatf("hold c%0d", c), 0);
            check_eq($sformatf("hold c%0d timeout", c), 32'(timeout), 32'd0);
        end
        tick();
        check_idle("forced rel");
        check_eq("forced timeout", 32'(timeout), 32'd1);
        req = 8'h00;
        tick();
        check_eq("timeout pulse end", 32'(timeout), 32'd0);
`else
        for (int c = 2; c <= 22; c++) begin
            tick();
            check_grant($sformatf("hold c%0d", c), 0);
            check_eq($sformatf("hold c%0d timeout", c), 32'(timeout), 32'd0);
        end
        done = 1'b1;
        tick();
        check_idle("hold rel");
        check_eq("hold rel timeout", 32'(timeout), 32'd0);
        done = 1'b0;
        req  = 8'h00;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
